uart_bus_master: RTL and testbench
==================================

// Module: uart_bus_master
// PURPOSE
// - UART-driven bus initiator for debug/program loading: receives 8N1 command frames on uart_rx and
//   issues single 32-bit reads/writes on the IO request/response interface as the master side.
// - Sits between an external host (PC serial port) and the system interconnect, alongside the UART peripheral.
// - Returns the status byte or read data on uart_tx.
// PARAMETERS
// - CLOCK_FREQUENCY   50000000  clock rate in Hz
// - UART_BAUD_RATE    9600      line rate; CYCLES_PER_BAUD = CLOCK_FREQUENCY/UART_BAUD_RATE, must exceed 50
// - RESPONSE_TIMEOUT  1024      cycles to wait for read/write_response (only with UART_BUS_MASTER_TIMEOUT_EN)
// PORTS
// - clock           in   1   system clock, all logic on rising edge
// - reset_n         in   1   synchronous, active-low reset
// - uart_rx         in   1   serial input, idle high
// - uart_tx         out  1   serial output, idle high
// - rw_address      out  32  bus address, stable while any request is high
// - write_data      out  32  bus write data, stable while write_request is high
// - write_request   out  1   write request level
// - write_response  in   1   write completion
// - read_data       in   32  bus read data, valid when read_response is high
// - read_request    out  1   read request level
// - read_response   in   1   read completion
// - busy            out  1   high from the first command byte until the reply is fully sent
// BEHAVIOUR
// - Reset (reset_n=0 at a clock edge): uart_tx=1, all requests 0, rw_address=0, write_data=0, busy=0,
//   FSM=IDLE, RX/TX counters 0. Reset mid-frame or mid-bus-cycle aborts silently; no reply is sent.
// - RX: a low uart_rx is held for CYCLES_PER_BAUD/2 cycles (start confirmed), then 8 data bits LSB-first
//   are sampled every CYCLES_PER_BAUD cycles, then the stop bit. Stop bit=0 is a framing error: byte dropped,
//   FSM returns to IDLE, no reply. A start glitch that ends before the half-baud point is ignored.
// - TX: 10-bit frame {1, byte, 0} shifted LSB-first, one bit per CYCLES_PER_BAUD+1 cycles, same timing as the UART peripheral.
// - Frames (multi-byte fields are MSB-first):
//   'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> bus write -> reply 0x4B 'K'
//   'R'(0x52) A3 A2 A1 A0             -> bus read  -> reply 4 bytes of read_data, MSB first
//   any other first byte              -> reply 0x3F '?', return to IDLE
// - FSM: IDLE -> CMD_ADDR(4 bytes) -> [W: CMD_DATA(4 bytes) -> BUS_WR] | [R: BUS_RD] -> REPLY -> IDLE.
//   Byte counter 2 bits, wraps 3->0 on the transition out of each field state.
// - Bus handshake: the request rises on the cycle after the last field byte is captured. It is held until
//   the response is sampled high. It is deasserted on the next edge, at which point REPLY is entered.
//   Only one request is ever high at once.
//   A response that arrives while no request is pending is ignored. A response in the same cycle the
//   request rises is accepted (minimum bus latency 1 cycle).
// - read_data is captured into the 32-bit reply shift register on the accepting edge.
// - Bytes arriving during BUS_WR, BUS_RD or REPLY are discarded; the RX deserializer keeps running so it stays
//   frame-aligned.
// - busy rises on the edge that captures the command byte. It falls on the edge after the stop bit of the
//   last reply byte completes. A '?' reply also holds busy for its duration.
// - No inter-byte timeout: a partial frame waits indefinitely for the remaining bytes.
// CONFIGURATION
// - UART_BUS_MASTER_TIMEOUT_EN defined: a 32-bit counter runs in BUS_WR/BUS_RD. When RESPONSE_TIMEOUT
//   cycles pass with no response, the request drops and the block replies 0x45 'E'. For a read,
//   no data bytes are sent.
// - UART_BUS_MASTER_TIMEOUT_EN not defined: no counter. The block waits for a response forever and never
//   sends 'E'.
// TESTING (CLOCK_FREQUENCY=10000000, UART_BAUD_RATE=100000, so 100 cycles/baud)
// - Host sends 57 80 00 00 10 DE AD BE EF; response after 3 cycles ->
//   rw_address=0x80000010, write_data=0xDEADBEEF, one write cycle, uart_tx carries 0x4B, busy 0 after.
// - Host sends 52 00 00 01 00; read_data=0x12345678 with response 1 cycle after request ->
//   uart_tx carries 12 34 56 78 in order.
// - Host sends 0x41 -> reply 0x3F, no request asserted; then a valid 'R' frame completes normally.
// - Byte 0x52 sent with stop bit 0 -> no reply, busy 0. Following 52 00 00 00 04 -> a normal read
//   at 0x00000004.
// - reset_n low for 1 cycle after 3 address bytes of a 'W' -> all outputs at reset values, no reply.
//   A subsequent full 'W' frame succeeds.
// - TIMEOUT_EN, RESPONSE_TIMEOUT=16, response never asserted -> request high exactly 16 cycles,
//   then the reply 0x45.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART-driven 32-bit bus master: 8N1 command frames on uart_rx, status or read data back on uart_tx.
// Optional response timeout is compiled in when UART_BUS_MASTER_TIMEOUT_EN is defined.
module uart_bus_master #(
  parameter int unsigned CLOCK_FREQUENCY  = 50000000,
  parameter int unsigned UART_BAUD_RATE   = 9600,
  parameter int unsigned RESPONSE_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] rw_address,
  output logic [31:0] write_data,
  output logic        write_request,
  input  logic        write_response,
  input  logic [31:0] read_data,
  output logic        read_request,
  input  logic        read_response,
  output logic        busy
);

  localparam int unsigned CyclesPerBaud = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int unsigned CntW          = $clog2(CyclesPerBaud + 2);
  localparam logic [CntW-1:0] BaudLast  = CntW'(CyclesPerBaud - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(CyclesPerBaud / 2 - 1);
  localparam logic [CntW-1:0] TxBitLast = CntW'(CyclesPerBaud);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;
  typedef enum logic [2:0] {StIdle, StCmdAddr, StCmdData, StBusWr, StBusRd, StReply} state_e;

  rx_state_e       rx_state;
  logic            rx_meta, rx_sync;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_byte;
  logic            rx_valid, rx_ferr;

  logic            tx_active, tx_load;
  logic [7:0]      tx_byte;
  logic [8:0]      tx_shift;
  logic [CntW-1:0] tx_cnt;
  logic [3:0]      tx_bit;

  state_e          state;
  logic [1:0]      byte_cnt;
  logic            is_write;
  logic [31:0]     reply_shift;
  logic [2:0]      reply_left;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [31:0]     to_cnt;
`endif

  // Receiver; after a framing error it waits for the line to go high before hunting again.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RxIdle;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (rx_state)
        RxIdle: begin
          if (!rx_sync) begin
            rx_state <= RxStart;
            rx_cnt   <= '0;
          end
        end
        RxStart: begin
          if (rx_sync) begin
            rx_state <= RxIdle;
          end else if (rx_cnt == HalfLast) begin
            rx_state <= RxData;
            rx_cnt   <= '0;
            rx_bit   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt == BaudLast) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            rx_bit  <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RxStop;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt == BaudLast) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_state <= RxIdle;
            end else begin
              rx_ferr  <= 1'b1;
              rx_state <= RxBreak;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RxBreak: begin
          if (rx_sync) rx_state <= RxIdle;
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // Transmitter: start bit driven on load, then 8 data bits and the stop bit from tx_shift.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uart_tx   <= 1'b1;
      tx_active <= 1'b0;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (!tx_active) begin
      if (tx_load) begin
        tx_active <= 1'b1;
        uart_tx   <= 1'b0;
        tx_shift  <= {1'b1, tx_byte};
        tx_cnt    <= '0;
        tx_bit    <= '0;
      end
    end else if (tx_cnt == TxBitLast) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_active <= 1'b0;
      end else begin
        uart_tx  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= StIdle;
      byte_cnt      <= '0;
      is_write      <= 1'b0;
      reply_shift   <= '0;
      reply_left    <= '0;
      tx_load       <= 1'b0;
      tx_byte       <= '0;
      rw_address    <= '0;
      write_data    <= '0;
      write_request <= 1'b0;
      read_request  <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      tx_load <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rx_valid) begin
            busy     <= 1'b1;
            byte_cnt <= '0;
            if (rx_byte == CmdWrite || rx_byte == CmdRead) begin
              is_write <= (rx_byte == CmdWrite);
              state    <= StCmdAddr;
            end else begin
              reply_shift <= {8'h3F, 24'h0};
              reply_left  <= 3'd1;
              state       <= StReply;
            end
          end
        end
        StCmdAddr: begin
          if (rx_ferr) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            rw_address <= {rw_address[23:0], rx_byte};
            byte_cnt   <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= StCmdData;
              end else begin
                state        <= StBusRd;
                read_request <= 1'b1;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
                to_cnt       <= '0;
`endif
              end
            end
          end
        end
        StCmdData: begin
          if (rx_ferr) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            write_data <= {write_data[23:0], rx_byte};
            byte_cnt   <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              state         <= StBusWr;
              write_request <= 1'b1;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
              to_cnt        <= '0;
`endif
            end
          end
        end
        StBusWr: begin
          if (write_response) begin
            write_request <= 1'b0;
            reply_shift   <= {8'h4B, 24'h0};
            reply_left    <= 3'd1;
            state         <= StReply;
          end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
          else if (to_cnt == 32'(RESPONSE_TIMEOUT - 1)) begin
            write_request <= 1'b0;
            reply_shift   <= {8'h45, 24'h0};
            reply_left    <= 3'd1;
            state         <= StReply;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        StBusRd: begin
          if (read_response) begin
            read_request <= 1'b0;
            reply_shift  <= read_data;
            reply_left   <= 3'd4;
            state        <= StReply;
          end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
          else if (to_cnt == 32'(RESPONSE_TIMEOUT - 1)) begin
            read_request <= 1'b0;
            reply_shift  <= {8'h45, 24'h0};
            reply_left   <= 3'd1;
            state        <= StReply;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        StReply: begin
          // tx_load is checked too because tx_active lags the load pulse by one cycle.
          if (!tx_active && !tx_load) begin
            if (reply_left == 3'd0) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              tx_load     <= 1'b1;
              tx_byte     <= reply_shift[31:24];
              reply_shift <= {reply_shift[23:0], 8'h00};
              reply_left  <= reply_left - 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: host UART driver, reply decoder, bus responder and a frame-level
// reference model that predicts bus transactions and reply bytes.
module tb_uart_bus_master;

  localparam int Cpb = 100;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        uart_rx;
  logic        uart_tx;
  logic [31:0] rw_address;
  logic [31:0] write_data;
  logic        write_request;
  logic        write_response;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic        busy;

  always #5 clock = ~clock;

  uart_bus_master #(
    .CLOCK_FREQUENCY (10000000),
    .UART_BAUD_RATE  (100000),
    .RESPONSE_TIMEOUT(16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .rw_address    (rw_address),
    .write_data    (write_data),
    .write_request (write_request),
    .write_response(write_response),
    .read_data     (read_data),
    .read_request  (read_request),
    .read_response (read_response),
    .busy          (busy)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int checks = 0;
  int errors = 0;

  txn_t        txn_q[$];
  logic [7:0]  reply_q[$];
  int          resp_lat = 0;
  bit          resp_never = 0;
  logic [31:0] rdata_next = '0;
  int          req_hi = 0;
  int          last_req_hi = 0;
  int          waited = 0;
  bit          served = 0;
  logic [31:0] held_addr, held_data;
  int          bus_viol = 0;
  int          stop_err = 0;
  logic [7:0]  mon_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus slave: answers after resp_lat cycles, injects stray responses while idle.
  initial begin
    write_response = 1'b0;
    read_response  = 1'b0;
    read_data      = $urandom;
    forever begin
      @(negedge clock);
      write_response = 1'b0;
      read_response  = 1'b0;
      read_data      = $urandom;
      if (write_request && read_request) bus_viol++;
      if (write_request || read_request) begin
        if (req_hi == 0) begin
          held_addr = rw_address;
          held_data = write_data;
          waited    = 0;
        end else if (rw_address !== held_addr || (write_request && write_data !== held_data)) begin
          bus_viol++;
        end
        req_hi++;
        if (!resp_never && !served && waited == resp_lat) begin
          served = 1;
          if (write_request) begin
            write_response = 1'b1;
            txn_q.push_back('{1'b1, rw_address, write_data});
          end else begin
            read_response = 1'b1;
            read_data     = rdata_next;
            txn_q.push_back('{1'b0, rw_address, rdata_next});
          end
        end else begin
          waited++;
        end
      end else begin
        if (req_hi != 0) last_req_hi = req_hi;
        req_hi = 0;
        served = 0;
        write_response = ($urandom_range(0, 7) == 0);
        read_response  = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Reply decoder at CYCLES_PER_BAUD+1 cycles per bit.
  initial begin
    forever begin
      @(negedge clock);
      if (uart_tx === 1'b0) begin
        repeat (Cpb / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb + 1) @(negedge clock);
          mon_b[i] = uart_tx;
        end
        repeat (Cpb + 1) @(negedge clock);
        if (uart_tx !== 1'b1) stop_err++;
        reply_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (Cpb) @(negedge clock);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    repeat (20) @(negedge clock);
  endtask

  // Send one frame and compare against what the frame rules predict.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
    logic [7:0] exp_reply[$];
    bit         is_wr, is_rd;
    is_wr = (cmd == 8'h57);
    is_rd = (cmd == 8'h52);
    txn_q.delete();
    reply_q.delete();
    resp_lat   = lat;
    rdata_next = rdata;
    send_byte(cmd, 1'b1);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
    if (is_wr || is_rd)
      for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8], 1'b1);
    if (is_wr)
      for (int i = 0; i < 4; i++) send_byte(wdata[31-8*i -: 8], 1'b1);
    wait_idle(tag);

    if (is_wr)      exp_reply = '{8'h4B};
    else if (is_rd) exp_reply = '{rdata[31:24], rdata[23:16], rdata[15:8], rdata[7:0]};
    else            exp_reply = '{8'h3F};

    check_eq({tag, "_ntxn"}, txn_q.size(), (is_wr || is_rd) ? 32'd1 : 32'd0);
    if (txn_q.size() > 0 && (is_wr || is_rd)) begin
      check_eq({tag, "_kind"}, {31'b0, txn_q[0].wr}, {31'b0, is_wr});
      check_eq({tag, "_addr"}, txn_q[0].addr, addr);
      if (is_wr) check_eq({tag, "_wdata"}, txn_q[0].data, wdata);
    end
    check_eq({tag, "_nreply"}, reply_q.size(), exp_reply.size());
    for (int i = 0; i < exp_reply.size(); i++)
      if (i < reply_q.size()) check_eq($sformatf("%s_byte%0d", tag, i), reply_q[i], exp_reply[i]);
    check_eq({tag, "_req_low"}, {30'b0, write_request, read_request}, 32'd0);
  endtask

  initial begin
    logic [7:0]  cmd;
    int          kind;
    reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("rst_tx", {31'b0, uart_tx}, 32'd1);
    check_eq("rst_req", {30'b0, write_request, read_request}, 32'd0);
    check_eq("rst_addr", rw_address, 32'd0);
    check_eq("rst_wdata", write_data, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);

    run_frame("wr", 8'h57, 32'h80000010, 32'hDEADBEEF, 32'h0, 3);
    run_frame("rd", 8'h52, 32'h00000100, 32'h0, 32'h12345678, 1);
    run_frame("bad", 8'h41, 32'h0, 32'h0, 32'h0, 0);
    run_frame("bad_rd", 8'h52, $urandom, 32'h0, $urandom, 0);

    // Framing error on the command byte: nothing happens.
    txn_q.delete();
    reply_q.delete();
    send_byte(8'h52, 1'b0);
    repeat (300) @(negedge clock);
    check_eq("fe_busy", {31'b0, busy}, 32'd0);
    check_eq("fe_nreply", reply_q.size(), 32'd0);
    check_eq("fe_ntxn", txn_q.size(), 32'd0);
    run_frame("fe_rd", 8'h52, 32'h00000004, 32'h0, $urandom, 2);

    // Reset in the middle of a write frame.
    txn_q.delete();
    reply_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("mrst_tx", {31'b0, uart_tx}, 32'd1);
    check_eq("mrst_req", {30'b0, write_request, read_request}, 32'd0);
    check_eq("mrst_addr", rw_address, 32'd0);
    check_eq("mrst_wdata", write_data, 32'd0);
    check_eq("mrst_busy", {31'b0, busy}, 32'd0);
    repeat (1500) @(negedge clock);
    check_eq("mrst_nreply", reply_q.size(), 32'd0);
    check_eq("mrst_ntxn", txn_q.size(), 32'd0);
    run_frame("mrst_wr", 8'h57, 32'h80000010, 32'hCAFEF00D, 32'h0, 0);

    for (int it = 0; it < 2; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) cmd = 8'h57;
      else if (kind == 1) cmd = 8'h52;
      else begin
        cmd = 8'($urandom_range(0, 255));
        while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom_range(0, 255));
      end
      run_frame($sformatf("rnd%0d", it), cmd, $urandom, $urandom, $urandom,
                $urandom_range(0, 5));
    end

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    txn_q.delete();
    reply_q.delete();
    resp_never  = 1;
    last_req_hi = 0;
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
    wait_idle("to");
    check_eq("to_req_cycles", last_req_hi, 32'd16);
    check_eq("to_ntxn", txn_q.size(), 32'd0);
    check_eq("to_nreply", reply_q.size(), 32'd1);
    if (reply_q.size() > 0) check_eq("to_byte", reply_q[0], 32'h45);
    resp_never = 0;
`endif

    check_eq("bus_protocol", bus_viol, 32'd0);
    check_eq("tx_stop_bits", stop_err, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
